// File: rtl/arcade_input_cond.sv
// Input conditioning ahead of control-port muxing: synchronizes and debounces
// both players' raw controls, shapes the coin line into frame-timed pulses, and edge-detects pause.
module arcade_input_cond #(
  parameter int unsigned NBITS       = 10,
  parameter int unsigned DB_LEN      = 4,
  parameter int unsigned COIN_FRAMES = 3,
  parameter int unsigned COIN_GAP    = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             vblank,
  input  logic [NBITS-1:0] joy1_in,
  input  logic [NBITS-1:0] joy2_in,
  output logic [NBITS-1:0] joy1_out,
  output logic [NBITS-1:0] joy2_out,
  output logic             coin_out,
  output logic [7:0]       coin_cnt,
  output logic             pause_pulse
);

  localparam int unsigned CW        = 4;
  localparam int unsigned TBITS     = 2 * NBITS;
  localparam int unsigned COIN_BIT  = 8;
  localparam int unsigned PAUSE_BIT = 9;

  localparam logic [CW-1:0]    DB_LAST  = CW'(DB_LEN - 1);
  localparam logic [CW-1:0]    FRAMES_L = CW'(COIN_FRAMES);
  localparam logic [CW-1:0]    GAP_L    = CW'(COIN_GAP);
  localparam logic [NBITS-1:0] OUT_MASK = ~(NBITS'(1) << COIN_BIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [TBITS-1:0] joy_s1, joy_s2;
  logic             vb_s1, vb_s2, vb_d;
  logic [TBITS-1:0] db_q;
  logic             coin_prev, pause_prev;

  logic             vb_rise_c, coin_req_c, coin_lvl_c, pause_lvl_c, gap_done_c;

  state_t           state, state_n;
  logic [CW-1:0]    frm_cnt, frm_cnt_n;
  logic             pending, pending_n;
  logic             coin_out_n;
  logic [7:0]       coin_cnt_n;

  // Two-flop synchronizers for both players and vblank
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_s1 <= '0;
      joy_s2 <= '0;
      vb_s1  <= 1'b0;
      vb_s2  <= 1'b0;
      vb_d   <= 1'b0;
    end else begin
      joy_s1 <= {joy2_in, joy1_in};
      joy_s2 <= joy_s1;
      vb_s1  <= vblank;
      vb_s2  <= vb_s1;
      vb_d   <= vb_s2;
    end
  end

  // Per-bit debounce: flips only after DB_LEN consecutive disagreeing samples
  for (genvar i = 0; i < TBITS; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (ce) begin
        if (joy_s2[i] == q) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt <= '0;
          q   <= ~q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign db_q[i] = q;
  end

  assign joy1_out = db_q[NBITS-1:0] & OUT_MASK;
  assign joy2_out = db_q[TBITS-1:NBITS] & OUT_MASK;

  assign coin_lvl_c  = db_q[COIN_BIT] | db_q[NBITS + COIN_BIT];
  assign pause_lvl_c = db_q[PAUSE_BIT] | db_q[NBITS + PAUSE_BIT];
  assign coin_req_c  = coin_lvl_c & ~coin_prev;
  assign vb_rise_c   = vb_s2 & ~vb_d;

  // Edge detectors on the merged player levels
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_prev   <= 1'b0;
      pause_prev  <= 1'b0;
      pause_pulse <= 1'b0;
    end else begin
      coin_prev   <= coin_lvl_c;
      pause_prev  <= pause_lvl_c;
      pause_pulse <= pause_lvl_c & ~pause_prev;
    end
  end

  // Coin shaper state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      frm_cnt  <= '0;
      pending  <= 1'b0;
      coin_out <= 1'b0;
      coin_cnt <= '0;
    end else begin
      state    <= state_n;
      frm_cnt  <= frm_cnt_n;
      pending  <= pending_n;
      coin_out <= coin_out_n;
      coin_cnt <= coin_cnt_n;
    end
  end

  // Coin shaper next state; a request coinciding with the gap exit is consumed there
  always_comb begin
    state_n    = state;
    frm_cnt_n  = frm_cnt;
    pending_n  = pending;
    coin_out_n = coin_out;
    coin_cnt_n = coin_cnt;
    gap_done_c = 1'b0;

    case (state)
      IDLE: begin
        if (coin_req_c) begin
          state_n    = ACTIVE;
          coin_out_n = 1'b1;
          frm_cnt_n  = '0;
          coin_cnt_n = coin_cnt + 8'd1;
        end
      end

      ACTIVE: begin
        if (coin_req_c) pending_n = 1'b1;
        if (vb_rise_c) begin
          if (frm_cnt + CW'(1) == FRAMES_L) begin
            state_n    = GAP;
            coin_out_n = 1'b0;
            frm_cnt_n  = '0;
          end else begin
            frm_cnt_n = frm_cnt + CW'(1);
          end
        end
      end

      GAP: begin
        gap_done_c = (GAP_L == '0) || (vb_rise_c && (frm_cnt + CW'(1) == GAP_L));
        if (coin_req_c) pending_n = 1'b1;
        if (vb_rise_c) frm_cnt_n = frm_cnt + CW'(1);
        if (gap_done_c) begin
          frm_cnt_n = '0;
          if (pending || coin_req_c) begin
            state_n    = ACTIVE;
            pending_n  = 1'b0;
            coin_out_n = 1'b1;
            coin_cnt_n = coin_cnt + 8'd1;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n    = IDLE;
        coin_out_n = 1'b0;
        frm_cnt_n  = '0;
        pending_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: debounce, coin shaping/queueing, pause pulse,
// counter wrap, plus a COIN_GAP=0 instance for the back-to-back pulse case.
module tb_arcade_input_cond;

  localparam int unsigned NBITS = 10;

  logic             clk_sys;
  logic             reset_n;
  logic             ce;
  logic             vblank;
  logic [NBITS-1:0] joy1_in, joy2_in;
  logic [NBITS-1:0] joy1_out, joy2_out;
  logic             coin_out;
  logic [7:0]       coin_cnt;
  logic             pause_pulse;

  logic [NBITS-1:0] joy1_out0, joy2_out0;
  logic             coin_out0;
  logic [7:0]       coin_cnt0;
  logic             pause_pulse0;

  int n_checks = 0;
  int n_errors = 0;

  int   coin_rises = 0;
  int   pause_hi   = 0;
  logic co_prev    = 1'b0;
  int   low_run0   = 0;
  int   last_low0  = -1;
  logic co0_prev   = 1'b0;
  logic [2:0] ce_div = '0;

  arcade_input_cond #(.NBITS(NBITS), .DB_LEN(4), .COIN_FRAMES(3), .COIN_GAP(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .vblank(vblank),
    .joy1_in(joy1_in), .joy2_in(joy2_in), .joy1_out(joy1_out), .joy2_out(joy2_out),
    .coin_out(coin_out), .coin_cnt(coin_cnt), .pause_pulse(pause_pulse)
  );

  arcade_input_cond #(.NBITS(NBITS), .DB_LEN(4), .COIN_FRAMES(3), .COIN_GAP(0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .vblank(vblank),
    .joy1_in(joy1_in), .joy2_in(joy2_in), .joy1_out(joy1_out0), .joy2_out(joy2_out0),
    .coin_out(coin_out0), .coin_cnt(coin_cnt0), .pause_pulse(pause_pulse0)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ce: one cycle in eight
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk_sys);
      ce_div = ce_div + 3'd1;
      ce     = (ce_div == 3'd0);
    end
  end

  // Event counters for pulse shapes
  always @(negedge clk_sys) begin
    co_prev <= coin_out;
    if (coin_out && !co_prev) coin_rises <= coin_rises + 1;
    if (pause_pulse) pause_hi <= pause_hi + 1;
    co0_prev <= coin_out0;
    if (coin_out0) begin
      if (!co0_prev) last_low0 <= low_run0;
      low_run0 <= 0;
    end else begin
      low_run0 <= low_run0 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    joy1_in = '0;
    joy2_in = '0;
    vblank  = 1'b0;
    reset_n = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
  endtask

  task automatic vb_pulse(input int n);
    repeat (n) begin
      vblank = 1'b1;
      wait_clk(4);
      vblank = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic press(input int player, input int idx);
    if (player == 1) joy1_in[idx] = 1'b1;
    else             joy2_in[idx] = 1'b1;
    wait_clk(48);
    if (player == 1) joy1_in[idx] = 1'b0;
    else             joy2_in[idx] = 1'b0;
    wait_clk(48);
  endtask

  int r0;
  int p0;

  initial begin
    reset_n = 1'b1;
    vblank  = 1'b0;
    joy1_in = '0;
    joy2_in = '0;
    #1;
    do_reset();

    check("rst_joy1", 32'(joy1_out), 32'h0);
    check("rst_joy2", 32'(joy2_out), 32'h0);
    check("rst_coin", 32'(coin_out), 32'h0);
    check("rst_cnt", 32'(coin_cnt), 32'h0);
    check("rst_pause", 32'(pause_pulse), 32'h0);

    // Glitch of three samples is rejected
    joy1_in[0] = 1'b1;
    wait_clk(24);
    joy1_in[0] = 1'b0;
    wait_clk(16);
    check("db_glitch", 32'(joy1_out), 32'h0);

    // Four samples flip the bit
    joy1_in[0] = 1'b1;
    wait_clk(24);
    check("db_early", 32'(joy1_out), 32'h0);
    wait_clk(12);
    check("db_flip", 32'(joy1_out), 32'h001);
    joy1_in[0] = 1'b0;
    wait_clk(48);
    check("db_release", 32'(joy1_out), 32'h0);

    joy2_in = 10'h0A6;
    wait_clk(48);
    check("db_joy2_word", 32'(joy2_out), 32'h0A6);
    joy2_in = '0;
    wait_clk(48);
    check("db_joy2_clr", 32'(joy2_out), 32'h0);

    // Single coin: three frames high
    do_reset();
    r0 = coin_rises;
    joy1_in[8] = 1'b1;
    wait_clk(48);
    check("coin_bit8_masked", 32'(joy1_out), 32'h0);
    joy1_in[8] = 1'b0;
    wait_clk(48);
    check("coin1_high", 32'(coin_out), 32'h1);
    check("coin1_cnt", 32'(coin_cnt), 32'h1);
    vb_pulse(2);
    check("coin1_vb2", 32'(coin_out), 32'h1);
    vb_pulse(1);
    check("coin1_vb3", 32'(coin_out), 32'h0);
    vb_pulse(4);
    check("coin1_idle", 32'(coin_out), 32'h0);
    check("coin1_rises", 32'(coin_rises - r0), 32'h1);
    check("coin1_cnt_end", 32'(coin_cnt), 32'h1);

    // Queueing: one pending, extra requests dropped
    do_reset();
    r0 = coin_rises;
    press(1, 8);
    check("q_first", 32'(coin_out), 32'h1);
    press(1, 8);
    press(2, 8);
    check("q_cnt_active", 32'(coin_cnt), 32'h1);
    vb_pulse(3);
    check("q_gap", 32'(coin_out), 32'h0);
    press(1, 8);
    vb_pulse(3);
    check("q_gap3", 32'(coin_out), 32'h0);
    vb_pulse(1);
    check("q_second", 32'(coin_out), 32'h1);
    check("q_cnt2", 32'(coin_cnt), 32'h2);
    vb_pulse(3 + 4 + 3);
    check("q_no_third", 32'(coin_out), 32'h0);
    check("q_rises", 32'(coin_rises - r0), 32'h2);
    check("q_cnt_end", 32'(coin_cnt), 32'h2);

    // Both players coin together
    do_reset();
    r0 = coin_rises;
    joy1_in[8] = 1'b1;
    joy2_in[8] = 1'b1;
    wait_clk(48);
    joy1_in[8] = 1'b0;
    joy2_in[8] = 1'b0;
    wait_clk(48);
    check("both_coin", 32'(coin_out), 32'h1);
    check("both_cnt", 32'(coin_cnt), 32'h1);
    check("both_rises", 32'(coin_rises - r0), 32'h1);
    vb_pulse(7);

    // Pause from both players at once, then one player
    p0 = pause_hi;
    joy1_in[9] = 1'b1;
    joy2_in[9] = 1'b1;
    wait_clk(48);
    check("pause_lvl1", 32'(joy1_out[9]), 32'h1);
    check("pause_lvl2", 32'(joy2_out[9]), 32'h1);
    joy1_in[9] = 1'b0;
    joy2_in[9] = 1'b0;
    wait_clk(48);
    check("pause_both", 32'(pause_hi - p0), 32'h1);
    press(2, 9);
    check("pause_single", 32'(pause_hi - p0), 32'h2);

    // Reset while a pulse is active and a coin is pending
    do_reset();
    press(1, 8);
    press(1, 8);
    check("rmid_active", 32'(coin_out), 32'h1);
    r0 = coin_rises;
    reset_n = 1'b0;
    #1;
    check("rmid_coin", 32'(coin_out), 32'h0);
    check("rmid_cnt", 32'(coin_cnt), 32'h0);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(2);
    vb_pulse(8);
    check("rmid_no_pending", 32'(coin_rises - r0), 32'h0);
    check("rmid_cnt_after", 32'(coin_cnt), 32'h0);

    // COIN_GAP=0: pending re-enters ACTIVE after one low cycle
    do_reset();
    press(1, 8);
    press(1, 8);
    check("g0_active", 32'(coin_out0), 32'h1);
    vb_pulse(3);
    check("g0_low_run", 32'(last_low0), 32'h1);
    check("g0_reentered", 32'(coin_out0), 32'h1);
    check("g0_cnt", 32'(coin_cnt0), 32'h2);
    vb_pulse(3);
    wait_clk(2);
    check("g0_idle", 32'(coin_out0), 32'h0);
    check("g0_cnt_end", 32'(coin_cnt0), 32'h2);

    // Counter wrap after 256 accepted coins
    do_reset();
    for (int k = 0; k < 256; k++) begin
      press(1, 8);
      vb_pulse(7);
      if (k == 254) check("wrap_255", 32'(coin_cnt), 32'hFF);
    end
    check("wrap_0", 32'(coin_cnt), 32'h0);
    check("wrap_idle", 32'(coin_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
